jtag_host: RTL
==============

Name: jtag_host

Overview:
- On-chip JTAG initiator (TAP master). It drives TCK/TMS/TDI/TRST_N toward a JTAG target and samples TDO.
- Used for self-test and bring-up: it exercises the core's debug TAP through the same pad-side JTAG signals an external probe would drive.
- Software or a test FSM issues IR-scan, DR-scan and TAP-reset commands over a valid/ready request/response interface.

Parameters:
- ClkDiv, 4: clk_i cycles per TCK half-period. Must be >= 1.
- MaxLen, 32: maximum scan length in bits.
- LenW, $clog2(MaxLen)+1: width of the length field (derived).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when valid&&ready
- req_kind_i  in  2  command kind: 0 = TAP reset, 1 = IR scan, 2 = DR scan, 3 = reserved (treated as TAP reset)
- req_len_i  in  LenW  scan length in bits
- req_data_i  in  MaxLen  TDI bits, bit 0 shifted first
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_data_o  out  MaxLen  captured TDO bits, first captured bit in bit 0
- jtag_tck_o  out  1  TCK
- jtag_tms_o  out  1  TMS
- jtag_tdi_o  out  1  TDI
- jtag_trst_no  out  1  TAP reset, active low
- jtag_tdo_i  in  1  TDO from the target (synchronised internally, 2 flops)

Behaviour:
- Reset values:
  - jtag_tck_o = 0, jtag_tms_o = 1, jtag_tdi_o = 0, jtag_trst_no = 0.
  - req_ready_o = 0, rsp_valid_o = 0, rsp_data_o = 0.
- TCK timing:
  - Each TCK period is ClkDiv clk cycles low, then ClkDiv cycles high.
  - TMS and TDI change only in the first clk cycle of a low phase.
  - TDO is sampled from the synchronised input in the last clk cycle of the high phase.
  - TCK is held at 0 when idle.
- Auto-reset: on rst_ni deassertion, the FSM (IDLE, RST, SEL, SHIFT, EXIT, RSP) enters RST without a request and runs the TAP-reset sequence. No response is produced for it.
- TAP-reset sequence: 6 TCK periods with TMS = 1,1,1,1,1,0.
  - jtag_trst_no = 0 during the first 5 periods; it becomes 1 at the start of period 6 and stays 1.
  - The TAP ends in Run-Test/Idle.
- req_ready_o = 1 only in IDLE: not during a command, not while rsp_valid_o = 1. It rises the clk cycle after the last TCK period of the auto-reset completes.
- Every command starts and ends with the TAP in Run-Test/Idle.
- DR scan:
  - TMS = 1,0,0 (Select-DR, Capture, Shift), then len shift periods with TMS = 0 except 1 on the last bit (Exit1).
  - Then TMS = 1 (Update), then 0 (Idle).
  - Total len+5 TCK periods.
- IR scan: preamble TMS = 1,1,0,0, then the same shift/postamble as DR. Total len+6 periods.
- TDI during shift periods = req_data_i[k] for shift period k. TDI = 0 in all non-shift periods.
- TDO captured on the rising edge of shift period k is written to rsp_data_o[k]. Bits >= len are 0.
- TAP-reset command (kinds 0 and 3): the 6-period sequence with jtag_trst_no held 1 (TMS-only reset); rsp_data_o = 0.
- Length rule: req_len_i = 0 or > MaxLen is clamped to MaxLen.
- Request fields are registered at acceptance; input changes after the handshake have no effect.
- Response:
  - rsp_valid_o rises the clk cycle after the final TCK period completes.
  - rsp_valid_o and rsp_data_o are held stable until rsp_ready_i.
  - req_ready_o returns to 1 the cycle after the response handshake.
  - rsp_ready_i held 1 beforehand does not shorten this: at most one response is outstanding.
- rst_ni asserted mid-command: the command is abandoned, outputs return to reset values immediately, and the auto-reset reruns after deassertion.

Test Plan:
- Auto-reset, ClkDiv=2 → exactly 6 TCK pulses, each 4 clk cycles; TMS 1,1,1,1,1,0; trst_no low for the first 20 clk cycles after release; req_ready_o=1 after cycle 24; no rsp_valid_o.
- DR scan, len=8, data=8'hA5, target loops TDI→TDO with 1-bit delay (model of a 1-bit DR) → 13 TCK periods; TDI bits 1,0,1,0,0,1,0,1 on shift periods 0-7; rsp_data_o = 32'h0000004A | captured bit0 from the capture flop (value 0) = 32'h0000004A.
- IR scan, len=5, data=5'h01, target drives TDO with IR capture pattern 5'b00001 → TMS 1,1,0,0,0,0,0,0,1,1,0 (11 periods); rsp_data_o = 32'h00000001.
- req_len_i = 0, DR scan, data 32'hDEADBEEF, TDO tied 1 → 37 TCK periods; rsp_data_o = 32'hFFFFFFFF.
- Backpressure: rsp_ready_i=0 for 50 cycles after rsp_valid_o → rsp_data_o stable, req_ready_o=0, TCK idle at 0; accept on ready, next request accepted the following cycle.
- rst_ni pulsed at shift bit 3 of a 16-bit DR scan → all outputs at reset values during the pulse; no response; the full 6-period auto-reset follows; a subsequent DR scan completes correctly.

Source files
------------

// File: rtl/jtag_host.sv
// jtag_host: on-chip JTAG initiator. Issues TAP-reset, IR-scan and DR-scan
// sequences on TCK/TMS/TDI/TRST_N and returns the captured TDO bits.
module jtag_host #(
    parameter int unsigned ClkDiv = 4,
    parameter int unsigned MaxLen = 32,
    parameter int unsigned LenW   = $clog2(MaxLen) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_kind_i,
    input  logic [LenW-1:0]   req_len_i,
    input  logic [MaxLen-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [MaxLen-1:0] rsp_data_o,
    output logic              jtag_tck_o,
    output logic              jtag_tms_o,
    output logic              jtag_tdi_o,
    output logic              jtag_trst_no,
    input  logic              jtag_tdo_i
);

    localparam int unsigned CntW = $clog2(2 * ClkDiv);

    typedef enum logic [2:0] {IDLE, RST, SEL, SHIFT, EXIT, RSP} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LenW-1:0]   per_q, per_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [MaxLen-1:0] data_q, data_d;
    logic [MaxLen-1:0] rsp_q, rsp_d;
    logic              ir_q, ir_d;
    logic              auto_q, auto_d;
    logic              tck_q, tck_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              trst_q, trst_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              tdo_meta_q, tdo_sync_q;
    logic              tick;

    // Two-flop synchroniser for the asynchronous TDO input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tdo_meta_q <= 1'b0;
            tdo_sync_q <= 1'b0;
        end else begin
            tdo_meta_q <= jtag_tdo_i;
            tdo_sync_q <= tdo_meta_q;
        end
    end

    // Next-state logic: per-period sequencing of TMS/TDI and TDO capture.
    // TMS/TDI for a period are loaded on the edge that enters its first cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        per_d       = per_q;
        len_d       = len_q;
        data_d      = data_q;
        rsp_d       = rsp_q;
        ir_d        = ir_q;
        auto_d      = auto_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        trst_d      = trst_q;
        ready_d     = ready_q;
        rsp_valid_d = rsp_valid_q;
        tick        = (cnt_q == CntW'(2 * ClkDiv - 1));

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    ready_d = 1'b0;
                    data_d  = req_data_i;
                    len_d   = (req_len_i == '0 || req_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : req_len_i;
                    ir_d    = (req_kind_i == 2'd1);
                    auto_d  = 1'b0;
                    rsp_d   = '0;
                    per_d   = '0;
                    cnt_d   = '0;
                    tms_d   = 1'b1;
                    tdi_d   = 1'b0;
                    state_d = (req_kind_i == 2'd1 || req_kind_i == 2'd2) ? SEL : RST;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (state_q == SHIFT && tick) begin
                    rsp_d = rsp_q | (MaxLen'(tdo_sync_q) << per_q);
                end
                if (tick) begin
                    per_d = per_q + 1'b1;
                    tdi_d = 1'b0;
                    case (state_q)
                        RST: begin
                            if (per_q == LenW'(5)) begin
                                state_d     = auto_q ? IDLE : RSP;
                                ready_d     = auto_q;
                                rsp_valid_d = !auto_q;
                            end else begin
                                tms_d = (per_q != LenW'(4));
                                if (per_q == LenW'(4)) begin
                                    trst_d = 1'b1;
                                end
                            end
                        end
                        SEL: begin
                            if (per_q == (ir_q ? LenW'(3) : LenW'(2))) begin
                                state_d = SHIFT;
                                per_d   = '0;
                                tms_d   = (len_q == LenW'(1));
                                tdi_d   = data_q[0];
                            end else begin
                                tms_d = ir_q && (per_q == '0);
                            end
                        end
                        SHIFT: begin
                            if (per_q + LenW'(1) == len_q) begin
                                state_d = EXIT;
                                per_d   = '0;
                                tms_d   = 1'b1;
                            end else begin
                                tms_d  = (per_q + LenW'(2) == len_q);
                                data_d = data_q >> 1;
                                tdi_d  = data_d[0];
                            end
                        end
                        EXIT: begin
                            if (per_q == '0) begin
                                tms_d = 1'b0;
                            end else begin
                                state_d     = RSP;
                                rsp_valid_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                tck_d = (cnt_d >= CntW'(ClkDiv));
            end
        endcase
    end

    // State register; reset lands in RST so the TAP-reset sequence runs on release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RST;
            cnt_q       <= '0;
            per_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            rsp_q       <= '0;
            ir_q        <= 1'b0;
            auto_q      <= 1'b1;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            len_q       <= len_d;
            data_q      <= data_d;
            rsp_q       <= rsp_d;
            ir_q        <= ir_d;
            auto_q      <= auto_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            trst_q      <= trst_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_q;
    assign jtag_tck_o   = tck_q;
    assign jtag_tms_o   = tms_q;
    assign jtag_tdi_o   = tdi_q;
    assign jtag_trst_no = trst_q;

endmodule
